// File: rtl/if_stage.sv
// Instruction fetch stage.
// Issues one 4-byte-aligned fetch at a time to instruction memory, collects
// the in-order responses into a 2-entry FIFO and presents the head entry to
// decode. A redirect flushes the FIFO, retargets the fetch PC and, if a
// request is still in flight, drains its response without buffering it.

module if_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request / response
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  // decode handshake
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc,
  output logic [6:0]  id_opcode,
  input  logic        id_ready,
  // control-flow redirect
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // may issue a request when the buffer has room
    ST_WAIT  = 2'd1,  // one live request outstanding, response is kept
    ST_DRAIN = 2'd2   // one stale request outstanding, response is dropped
  } state_t;

  // FSM and control registers
  state_t      state_q,    state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic [63:0] req_addr_q, req_addr_d;   // address of the outstanding request
  logic [1:0]  count_q,    count_d;
  logic        rd_ptr_q,   rd_ptr_d;
  logic        wr_ptr_q,   wr_ptr_d;
  logic        imem_req_q, imem_req_d;
  logic        id_valid_q, id_valid_d;

  // buffer storage (data only, qualified by count)
  logic [31:0] buf_instr_q [0:1];
  logic [63:0] buf_pc_q    [0:1];

  // per-cycle events
  logic accept_s;
  logic pop_s;
  logic push_s;

  // The request output is registered and is only ever high in FETCH, so it
  // doubles as the "we are in FETCH with room" qualifier for acceptance.
  assign accept_s = imem_req_q & imem_ready;
  assign pop_s    = id_valid_q & id_ready;
  assign push_s   = imem_rvalid & (state_q == ST_WAIT) & ~redirect_valid;

  // Next-state logic for the FSM, fetch PC, FIFO pointers and outputs
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (redirect_valid) begin
      // Redirect wins over everything except reset: flush the buffer and
      // retarget. A request still in flight (or accepted this very cycle)
      // must have its response swallowed, hence DRAIN.
      fetch_pc_d = redirect_pc & ~64'h0000_0000_0000_0003;
      count_d    = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (accept_s) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_WAIT, ST_DRAIN: begin
          // A response landing in the same cycle retires the stale request.
          if (imem_rvalid) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (accept_s) begin
            state_d    = ST_WAIT;
            req_addr_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 64'd4;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase

      // FIFO bookkeeping; a push never targets a full buffer because a
      // request is only issued while there is a free slot.
      if (push_s) begin
        wr_ptr_d = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, push_s} - {1'b0, pop_s};
    end

    imem_req_d = (state_d == ST_FETCH) && (count_d < BUF_DEPTH[1:0]);
    id_valid_d = (count_d != 2'd0);
  end

  // State register with synchronous reset; reset overrides redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      imem_req_q <= 1'b1;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      imem_req_q <= imem_req_d;
      id_valid_q <= id_valid_d;
    end
  end

  // Buffer storage write; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      buf_instr_q[wr_ptr_q] <= imem_rdata;
      buf_pc_q[wr_ptr_q]    <= req_addr_q;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = fetch_pc_q;
  assign id_valid  = id_valid_q;
  assign id_instr  = buf_instr_q[rd_ptr_q];
  assign id_pc     = buf_pc_q[rd_ptr_q];
  assign id_opcode = id_instr[6:0];

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by a random
// phase, all compared against a queue-based reference model of the stage.

module tb_if_stage;

  localparam logic [63:0] RST_PC = 64'h0000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [6:0]  id_opcode;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode),
    .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // reference model: buffered entries, next fetch address, in-flight request
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [63:0] m_pc = RST_PC;
  logic [63:0] m_out_addr = RST_PC;
  int          m_out = 0;          // 0 none, 1 live (keep), 2 stale (discard)

  // memory environment
  bit          mem_busy = 1'b0;
  bit          rdy_en = 1'b0;
  bit          stale_mode = 1'b0;
  int          mem_cnt = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [63:0] mem_addr = 64'd0;
  logic [63:0] issued[$];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] word_of(logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory, advance model and memory at the edge, check after it
  task automatic cyc();
    bit   exp_req;
    bit   acc_env;
    bit   acc_m;
    bit   pop;
    ent_t e;
    imem_rvalid = mem_busy && (mem_cnt == 0);
    imem_rdata  = imem_rvalid ? word_of(mem_addr) : $urandom;
    imem_ready  = rdy_en && !mem_busy;
    exp_req     = (m_out == 0) && (mq.size() < 2);
    #1;
    acc_env = imem_req && imem_ready && !rst;
    @(posedge clk);
    // memory
    if (imem_rvalid || (rst && !stale_mode)) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (acc_env) begin
      mem_busy = 1'b1;
      mem_addr = imem_addr;
      mem_cnt  = $urandom_range(lat_hi, lat_lo) - 1;
      issued.push_back(imem_addr);
    end
    // model
    if (rst) begin
      mq.delete();
      m_pc  = RST_PC;
      m_out = 0;
    end else begin
      acc_m = exp_req && imem_ready;
      pop   = (mq.size() > 0) && id_ready;
      if (redirect_valid) begin
        mq.delete();
        if (m_out != 0 && imem_rvalid) m_out = 0;
        else if (m_out != 0 || acc_m) m_out = 2;
        m_pc = redirect_pc & ~64'd3;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_out != 0 && imem_rvalid) begin
          if (m_out == 1) begin
            e.pc = m_out_addr;
            e.instr = imem_rdata;
            mq.push_back(e);
          end
          m_out = 0;
        end
        if (acc_m) begin
          m_out = 1;
          m_out_addr = m_pc;
          m_pc = m_pc + 64'd4;
        end
      end
    end
    #1;
    exp_req = (m_out == 0) && (mq.size() < 2);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", id_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_instr", id_instr, mq[0].instr);
      chk("id_opcode", id_opcode, mq[0].instr[6:0]);
    end
  endtask

  task automatic do_reset(bit stale);
    stale_mode = stale;
    redirect_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_req", imem_req, 1'b1);
    chk("rst_addr", imem_addr, RST_PC);
    cyc();
    rst = 1'b0;
    stale_mode = 1'b0;
    issued.delete();
  endtask

  // Step until a new request is issued or the budget runs out
  task automatic wait_issue(string tag, int n_before);
    for (int k = 0; k < 30 && issued.size() <= n_before; k++) cyc();
    chk(tag, issued.size() > n_before, 1'b1);
  endtask

  initial begin
    // basic stream: addresses 0,4,8 and first entry valid after first response
    lat_lo = 1; lat_hi = 1; rdy_en = 1'b1; id_ready = 1'b1;
    do_reset(1'b0);
    cyc(); cyc();
    chk("r34_valid", id_valid, 1'b1);
    chk("r34_pc0", id_pc, 64'h0);
    repeat (6) cyc();
    chk("r34_n", issued.size() >= 3, 1'b1);
    if (issued.size() >= 3) begin
      chk("r34_a0", issued[0], 64'h0);
      chk("r34_a1", issued[1], 64'h4);
      chk("r34_a2", issued[2], 64'h8);
    end

    // back-pressure: exactly two pushes, then one pop frees one request
    id_ready = 1'b0;
    do_reset(1'b0);
    repeat (10) cyc();
    chk("r35_req_off", imem_req, 1'b0);
    chk("r35_issued2", issued.size(), 2);
    chk("r35_head", id_pc, 64'h0);
    id_ready = 1'b1;
    cyc();
    id_ready = 1'b0;
    repeat (5) cyc();
    chk("r35_issued3", issued.size(), 3);
    chk("r35_head1", id_pc, 64'h4);

    // redirect while waiting: response dropped, fetch restarts at 0x1000
    lat_lo = 3; lat_hi = 3; id_ready = 1'b1;
    do_reset(1'b0);
    cyc();
    chk("r36_busy", issued.size(), 1);
    redirect_valid = 1'b1; redirect_pc = 64'h1002;
    cyc();
    redirect_valid = 1'b0;
    chk("r36_flush", id_valid, 1'b0);
    wait_issue("r36_reissue", 1);
    if (issued.size() >= 2) chk("r36_addr", issued[1], 64'h1000);
    for (int k = 0; k < 20 && !id_valid; k++) cyc();
    chk("r36_pc", id_pc, 64'h1000);

    // redirect together with response and pop
    lat_lo = 1; lat_hi = 1; id_ready = 1'b0;
    do_reset(1'b0);
    cyc(); cyc(); cyc();
    redirect_valid = 1'b1; redirect_pc = 64'h2000; id_ready = 1'b1;
    chk("r37_rvalid_next", mem_busy && mem_cnt == 0, 1'b1);
    cyc();
    redirect_valid = 1'b0;
    chk("r37_empty", id_valid, 1'b0);
    chk("r37_req", imem_req, 1'b1);
    chk("r37_addr", imem_addr, 64'h2000);

    // wrap of the fetch address
    rdy_en = 1'b0;
    do_reset(1'b0);
    cyc();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    cyc();
    redirect_valid = 1'b0; rdy_en = 1'b1;
    cyc(); cyc();
    chk("r38_addr", imem_addr, 64'h0);
    chk("r38_req", imem_req, 1'b1);
    chk("r38_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // reset while waiting with one entry buffered; stale response ignored
    lat_lo = 3; lat_hi = 3; id_ready = 1'b0;
    do_reset(1'b0);
    repeat (5) cyc();
    chk("r39_pre_valid", id_valid, 1'b1);
    chk("r39_pre_wait", imem_req, 1'b0);
    do_reset(1'b1);
    repeat (3) cyc();
    chk("r39_stale", id_valid, 1'b0);
    repeat (6) cyc();
    chk("r39_fresh_pc", id_pc, RST_PC);

    // random phase
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 2000; i++) begin
      rdy_en         = ($urandom_range(9, 0) < 7);
      id_ready       = ($urandom_range(9, 0) < 6);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = {$urandom, $urandom};
      rst            = ($urandom_range(299, 0) == 0);
      cyc();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
